// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: req/gnt request channel and rvalid/rdata response channel.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: EX/MEM -> req/gnt/rvalid data port -> MEM/WB, stalling upstream while an access is in flight.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses trap instead of reaching memory.
module mem_access_stage #(
  parameter int         XLEN      = 32,
  parameter logic [6:0] OPC_LOAD  = 7'b0000011,
  parameter logic [6:0] OPC_STORE = 7'b0100011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [XLEN-1:0]    ex_mem_ir,
  input  logic [XLEN-1:0]    ex_mem_alu,
  input  logic [XLEN-1:0]    ex_mem_b,
  output logic               stall_out,
  mem_access_stage_if.master dmem,
  output logic               mem_wb_valid,
  output logic [XLEN-1:0]    mem_wb_ir,
  output logic [XLEN-1:0]    mem_wb_alu,
  output logic [XLEN-1:0]    mem_wb_lmd,
  output logic               mem_wb_trap
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e          state_reg;
  size_e           size_next;
  size_e           size_reg;
  logic [1:0]      lane_reg;
  logic            unsigned_reg;

  logic [2:0]      funct3;
  logic [1:0]      lane;
  logic            is_load;
  logic            is_store;
  logic            is_mem;
  logic            trap_next;
  logic [3:0]      be_byte;
  logic [3:0]      be_half;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [XLEN-1:0] lmd_next;

  assign funct3   = ex_mem_ir[14:12];
  assign lane     = ex_mem_alu[1:0];
  assign is_load  = (ex_mem_ir[6:0] == OPC_LOAD);
  assign is_store = (ex_mem_ir[6:0] == OPC_STORE);
  assign is_mem   = is_load || is_store;

  // Undefined funct3 encodings fall through to word size; only loads have the unsigned variants.
  always_comb begin
    size_next = SZ_W;
    if (funct3 == 3'b000 || (is_load && funct3 == 3'b100))
      size_next = SZ_B;
    else if (funct3 == 3'b001 || (is_load && funct3 == 3'b101))
      size_next = SZ_H;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_next = is_mem && ((size_next == SZ_H && lane[0]) ||
                                (size_next == SZ_W && lane != 2'b00));
`else
  assign trap_next = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be_byte[gi] = (lane == 2'(gi));
      assign be_half[gi] = (lane[1] == (gi >= 2));
    end
  endgenerate

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = ex_mem_b;
    case (size_next)
      SZ_B: begin
        be_next    = be_byte;
        wdata_next = {4{ex_mem_b[7:0]}};
      end
      SZ_H: begin
        be_next    = be_half;
        wdata_next = {2{ex_mem_b[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the lane/size captured at issue, so the response path does not depend on EX/MEM.
  assign byte_sh = dmem.dmem_rdata >> {lane_reg, 3'b000};
  assign half_sh = dmem.dmem_rdata >> {lane_reg[1], 4'b0000};

  always_comb begin
    lmd_next = dmem.dmem_rdata;
    case (size_reg)
      SZ_B: lmd_next = unsigned_reg ? {{(XLEN-8){1'b0}}, byte_sh[7:0]}
                                    : {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      SZ_H: lmd_next = unsigned_reg ? {{(XLEN-16){1'b0}}, half_sh[15:0]}
                                    : {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    stall_out = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE:    stall_out = ex_valid && is_mem && !trap_next;
        REQ:     stall_out = !(dmem.dmem_gnt && dmem.dmem_we);
        WAIT:    stall_out = !dmem.dmem_rvalid;
        default: stall_out = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      size_reg        <= SZ_W;
      lane_reg        <= 2'b00;
      unsigned_reg    <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      mem_wb_valid    <= 1'b0;
      mem_wb_ir       <= '0;
      mem_wb_alu      <= '0;
      mem_wb_lmd      <= '0;
      mem_wb_trap     <= 1'b0;
    end else begin
      // MEM/WB always tracks EX/MEM; it is only marked valid on the cycle an instruction retires here.
      mem_wb_ir    <= ex_mem_ir;
      mem_wb_alu   <= ex_mem_alu;
      mem_wb_valid <= 1'b0;
      mem_wb_lmd   <= '0;
      mem_wb_trap  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              mem_wb_valid <= 1'b1;
            end else if (trap_next) begin
              mem_wb_valid <= 1'b1;
              mem_wb_trap  <= 1'b1;
            end else begin
              state_reg       <= REQ;
              size_reg        <= size_next;
              lane_reg        <= lane;
              unsigned_reg    <= funct3[2];
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= is_store;
              dmem.dmem_addr  <= {ex_mem_alu[31:2], 2'b00};
              dmem.dmem_be    <= be_next;
              dmem.dmem_wdata <= is_store ? wdata_next : '0;
            end
          end
        end
        REQ: begin
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            if (dmem.dmem_we) begin
              mem_wb_valid <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid) begin
            mem_wb_valid <= 1'b1;
            mem_wb_lmd   <= lmd_next;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed spec cases plus randomized ops against a byte-lane model.
module tb_mem_access_stage;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_mem_ir, ex_mem_alu, ex_mem_b;
  logic        stall_out;
  logic        mem_wb_valid, mem_wb_trap;
  logic [31:0] mem_wb_ir, mem_wb_alu, mem_wb_lmd;

  mem_access_stage_if dmem_bus();

  mem_access_stage dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_mem_ir    (ex_mem_ir),
    .ex_mem_alu   (ex_mem_alu),
    .ex_mem_b     (ex_mem_b),
    .stall_out    (stall_out),
    .dmem         (dmem_bus),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ir    (mem_wb_ir),
    .mem_wb_alu   (mem_wb_alu),
    .mem_wb_lmd   (mem_wb_lmd),
    .mem_wb_trap  (mem_wb_trap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Current-cycle expectations (stall, request) and next-cycle MEM/WB expectations.
  logic        exp_stall, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        pend_valid, pend_trap, exp_valid, exp_trap;
  logic [31:0] pend_ir, pend_alu, pend_lmd, exp_ir, exp_alu, exp_lmd;
  int          stall_cycles, req_cycles;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int acc_bytes(input logic [31:0] ir);
    logic [2:0] f3;
    f3 = ir[14:12];
    if (ir[6:0] == OPC_LOAD) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  // A lane is enabled when it falls in the same naturally aligned chunk as the address.
  function automatic logic [3:0] model_be(input logic [31:0] ir, input logic [31:0] alu);
    int nb;
    int a;
    logic [3:0] be;
    nb = acc_bytes(ir);
    a  = int'(alu[1:0]);
    for (int i = 0; i < 4; i++) be[i] = ((i / nb) == (a / nb));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] ir, input logic [31:0] b);
    int nb;
    logic [31:0] w;
    nb = acc_bytes(ir);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = b[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_lmd(input logic [31:0] ir, input logic [31:0] alu,
                                            input logic [31:0] rdata);
    int nb;
    int base;
    logic [31:0] v;
    logic sgn;
    nb   = acc_bytes(ir);
    base = (int'(alu[1:0]) / nb) * nb;
    v    = 32'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(base + i) +: 8];
    if (nb < 4 && !ir[14]) begin
      sgn = v[8*nb - 1];
      for (int i = 8*nb; i < 32; i++) v[i] = sgn;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    exp_valid <= pend_valid;
    exp_trap  <= pend_trap;
    exp_ir    <= pend_ir;
    exp_alu   <= pend_alu;
    exp_lmd   <= pend_lmd;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("stall_out", {31'd0, stall_out}, {31'd0, exp_stall});
      chk("dmem_req", {31'd0, dmem_bus.dmem_req}, {31'd0, exp_req});
      if (exp_req) begin
        chk("dmem_addr", dmem_bus.dmem_addr, exp_addr);
        chk("dmem_we", {31'd0, dmem_bus.dmem_we}, {31'd0, exp_we});
        if (exp_we) begin
          chk("dmem_be", {28'd0, dmem_bus.dmem_be}, {28'd0, exp_be});
          chk("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
        end
      end
      chk("mem_wb_valid", {31'd0, mem_wb_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("mem_wb_ir", mem_wb_ir, exp_ir);
        chk("mem_wb_alu", mem_wb_alu, exp_alu);
        chk("mem_wb_lmd", mem_wb_lmd, exp_lmd);
        chk("mem_wb_trap", {31'd0, mem_wb_trap}, {31'd0, exp_trap});
      end
      if (stall_out) stall_cycles++;
      if (dmem_bus.dmem_req) begin
        req_cycles++;
        last_addr  = dmem_bus.dmem_addr;
        last_be    = dmem_bus.dmem_be;
        last_wdata = dmem_bus.dmem_wdata;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
    chk({tag, "_req"}, {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, dmem_bus.dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_bus.dmem_addr, 32'd0);
    chk({tag, "_be"}, {28'd0, dmem_bus.dmem_be}, 32'd0);
    chk({tag, "_wdata"}, dmem_bus.dmem_wdata, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, mem_wb_valid}, 32'd0);
    chk({tag, "_wb_ir"}, mem_wb_ir, 32'd0);
    chk({tag, "_wb_alu"}, mem_wb_alu, 32'd0);
    chk({tag, "_wb_lmd"}, mem_wb_lmd, 32'd0);
    chk({tag, "_wb_trap"}, {31'd0, mem_wb_trap}, 32'd0);
  endtask

  // Drives one EX/MEM entry and plays the memory side with the given gnt/rvalid delays.
  task automatic run_op(input logic valid, input logic [31:0] ir, input logic [31:0] alu,
                        input logic [31:0] b, input int gdly, input int rdly, input logic [31:0] rdata);
    logic is_mem;
    logic is_st;
    logic trap;
    is_st  = valid && (ir[6:0] == OPC_STORE);
    is_mem = is_st || (valid && (ir[6:0] == OPC_LOAD));
`ifdef MEM_MISALIGN_TRAP_EN
    trap = is_mem && ((int'(alu[1:0]) % acc_bytes(ir)) != 0);
`else
    trap = 1'b0;
`endif
    ex_valid   = valid;
    ex_mem_ir  = ir;
    ex_mem_alu = alu;
    ex_mem_b   = b;
    pend_ir    = ir;
    pend_alu   = alu;
    pend_lmd   = 32'd0;
    pend_trap  = 1'b0;
    exp_req    = 1'b0;
    dmem_bus.dmem_gnt    = 1'($urandom_range(0, 1));
    dmem_bus.dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_bus.dmem_rdata  = $urandom;
    if (!is_mem || trap) begin
      exp_stall  = 1'b0;
      pend_valid = valid;
      pend_trap  = trap;
      tick;
    end else begin
      exp_stall  = 1'b1;
      pend_valid = 1'b0;
      exp_addr   = {alu[31:2], 2'b00};
      exp_we     = is_st;
      exp_be     = model_be(ir, alu);
      exp_wdata  = model_wdata(ir, b);
      tick;
      exp_req = 1'b1;
      for (int i = 0; i < gdly; i++) begin
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'($urandom_range(0, 1));
        tick;
      end
      dmem_bus.dmem_gnt    = 1'b1;
      dmem_bus.dmem_rvalid = 1'($urandom_range(0, 1));
      if (is_st) begin
        exp_stall  = 1'b0;
        pend_valid = 1'b1;
        tick;
      end else begin
        tick;
        exp_req           = 1'b0;
        dmem_bus.dmem_gnt = 1'b0;
        for (int i = 0; i < rdly; i++) begin
          dmem_bus.dmem_rvalid = 1'b0;
          dmem_bus.dmem_rdata  = $urandom;
          tick;
        end
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = rdata;
        exp_stall  = 1'b0;
        pend_valid = 1'b1;
        pend_lmd   = model_lmd(ir, alu, rdata);
        tick;
      end
    end
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
  endtask

  logic [31:0] ir_add, ir_sw, ir_sh, ir_lb, ir_lbu, ir_lhu, ir_lw, r_ir, r_alu;
  int kind;

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_mem_ir = '0; ex_mem_alu = '0; ex_mem_b = '0;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    pend_valid = 1'b0; pend_trap = 1'b0; pend_ir = '0; pend_alu = '0; pend_lmd = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
    stall_cycles = 0; req_cycles = 0;
    ir_add = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, OPC_OP};
    ir_sw  = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, OPC_STORE};
    ir_sh  = {7'd0, 5'd2, 5'd1, 3'b001, 5'd0, OPC_STORE};
    ir_lb  = {12'd0, 5'd1, 3'b000, 5'd3, OPC_LOAD};
    ir_lbu = {12'd0, 5'd1, 3'b100, 5'd3, OPC_LOAD};
    ir_lhu = {12'd0, 5'd1, 3'b101, 5'd3, OPC_LOAD};
    ir_lw  = {12'd0, 5'd1, 3'b010, 5'd3, OPC_LOAD};
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    reset = 1'b0;
    check_en = 1'b1;

    // Model pins against hand-computed values.
    chk("model_lb", model_lmd(ir_lb, 32'h103, 32'h8000_0000), 32'hFFFF_FF80);
    chk("model_sh_be", {28'd0, model_be(ir_sh, 32'h202)}, 32'h0000_000C);

    stall_cycles = 0;
    run_op(1'b1, ir_add, 32'h1234, 32'h0, 0, 0, 32'h0);
    chk("add_valid", {31'd0, mem_wb_valid}, 32'd1);
    chk("add_alu", mem_wb_alu, 32'h1234);
    chk("add_lmd", mem_wb_lmd, 32'h0);
    chk("add_stall_cycles", stall_cycles, 0);

    stall_cycles = 0; req_cycles = 0;
    run_op(1'b1, ir_sw, 32'h100, 32'hDEAD_BEEF, 2, 0, 32'h0);
    chk("sw_addr", last_addr, 32'h100);
    chk("sw_be", {28'd0, last_be}, 32'hF);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_stall_cycles", stall_cycles, 3);
    chk("sw_req_cycles", req_cycles, 3);

    run_op(1'b1, ir_lb, 32'h103, 32'h0, 0, 0, 32'h8000_0000);
    chk("lb_lmd", mem_wb_lmd, 32'hFFFF_FF80);
    run_op(1'b1, ir_lbu, 32'h103, 32'h0, 1, 2, 32'h8000_0000);
    chk("lbu_lmd", mem_wb_lmd, 32'h0000_0080);

    run_op(1'b1, ir_sh, 32'h202, 32'h0000_ABCD, 0, 0, 32'h0);
    chk("sh_be", {28'd0, last_be}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    run_op(1'b1, ir_lhu, 32'h202, 32'h0, 0, 0, 32'hABCD_0000);
    chk("lhu_lmd", mem_wb_lmd, 32'h0000_ABCD);

    // Reset while waiting for load data; a late rvalid must not produce a write.
    ex_valid = 1'b1; ex_mem_ir = ir_lb; ex_mem_alu = 32'h104; ex_mem_b = 32'h0;
    exp_stall = 1'b1; exp_req = 1'b0; pend_valid = 1'b0;
    exp_addr = 32'h104; exp_we = 1'b0;
    tick;
    dmem_bus.dmem_gnt = 1'b1; exp_req = 1'b1;
    tick;
    dmem_bus.dmem_gnt = 1'b0; exp_req = 1'b0;
    tick;
    check_en = 1'b0;
    reset = 1'b1; ex_valid = 1'b0; ex_mem_ir = '0; ex_mem_alu = '0;
    tick;
    reset = 1'b0;
    all_zero("rst_wait");
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h1234_5678;
    exp_stall = 1'b0; exp_req = 1'b0; pend_valid = 1'b0;
    check_en = 1'b1;
    tick;
    dmem_bus.dmem_rvalid = 1'b0;
    chk("rst_late_rvalid", {31'd0, mem_wb_valid}, 32'd0);
    run_op(1'b1, ir_add, 32'h55, 32'h0, 0, 0, 32'h0);
    chk("rst_then_add", mem_wb_alu, 32'h55);

    req_cycles = 0;
    run_op(1'b1, ir_lw, 32'h101, 32'h0, 0, 0, 32'hCAFE_F00D);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis_req_cycles", req_cycles, 0);
    chk("lw_mis_trap", {31'd0, mem_wb_trap}, 32'd1);
`else
    chk("lw_mis_addr", last_addr, 32'h100);
    chk("lw_mis_lmd", mem_wb_lmd, 32'hCAFE_F00D);
`endif

    for (int n = 0; n < 400; n++) begin
      kind  = $urandom_range(0, 9);
      r_ir  = $urandom;
      r_alu = $urandom;
      if (kind >= 1 && kind <= 3) r_ir[6:0] = (kind == 1) ? OPC_OP : 7'b0010011;
      else if (kind >= 4 && kind <= 6) r_ir[6:0] = OPC_LOAD;
      else if (kind >= 7) r_ir[6:0] = OPC_STORE;
      run_op(kind != 0, r_ir, r_alu, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    run_op(1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
